// File: rtl/pe_mac_sequencer.sv
// pe_mac_sequencer: feeds a term-major operand stream into one PE MAC unit,
// clears the PE before each job and collects its rounded results by slot.
module pe_mac_sequencer #(
  parameter int DATA_W  = 16,
  parameter int NUM_ACC = 8,
  parameter int K_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [K_W-1:0]    cfg_k_len,
  input  logic [3:0]        cfg_num_out,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              pe_rst_n,
  output logic [DATA_W-1:0] pe_data_in_1,
  output logic [DATA_W-1:0] pe_data_in_2,
  output logic [3:0]        pe_add_number,
  output logic              pe_rounder_en,
  input  logic [DATA_W-1:0] pe_data_out,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [3:0]        res_idx,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [K_W-1:0]      k_len_q, k_len_d;
  logic [3:0]          num_out_q, num_out_d;
  logic [K_W-1:0]      term_cnt_q, term_cnt_d;
  logic [3:0]          acc_cnt_q, acc_cnt_d;
  logic                op_ready_q, op_ready_d;
  logic                pe_rst_n_q, pe_rst_n_d;
  logic [DATA_W-1:0]   issue_a_q, issue_a_d;
  logic [DATA_W-1:0]   issue_b_q, issue_b_d;
  logic [3:0]          issue_slot_q, issue_slot_d;
  logic                issue_rnd_q, issue_rnd_d;
  logic [3:0]          pipe_vld_q, pipe_vld_d;
  logic [3:0][3:0]     pipe_slot_q, pipe_slot_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic [3:0]          res_idx_q, res_idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cfg_err_q, cfg_err_d;

  logic hs;
  logic cfg_ok;
  logic last_acc;
  logic last_term;

  // op_valid/op_ready: a pair transfers on every rising edge where both are
  // high; op_ready is only high in RUN and the producer holds op_a/op_b
  // stable while op_valid waits for it.
  always_comb begin
    state_d      = state_q;
    k_len_d      = k_len_q;
    num_out_d    = num_out_q;
    term_cnt_d   = term_cnt_q;
    acc_cnt_d    = acc_cnt_q;
    cfg_err_d    = 1'b0;
    issue_a_d    = '0;
    issue_b_d    = '0;
    issue_slot_d = '0;
    issue_rnd_d  = 1'b0;
    hs           = op_valid && op_ready_q;
    cfg_ok       = (cfg_k_len != '0) && (cfg_num_out != 4'd0) &&
                   (cfg_num_out <= 4'(NUM_ACC));
    last_acc     = (acc_cnt_q == num_out_q - 4'd1);
    last_term    = (term_cnt_q == k_len_q - K_W'(1));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_d    = S_CLEAR;
            k_len_d    = cfg_k_len;
            num_out_d  = cfg_num_out;
            term_cnt_d = '0;
            acc_cnt_d  = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        if (hs) begin
          issue_a_d    = op_a;
          issue_b_d    = op_b;
          issue_slot_d = acc_cnt_q;
          issue_rnd_d  = last_term;
          if (last_acc) begin
            acc_cnt_d  = '0;
            term_cnt_d = term_cnt_q + K_W'(1);
            if (last_term) state_d = S_DRAIN;
          end else begin
            acc_cnt_d = acc_cnt_q + 4'd1;
          end
        end
      end
      S_DRAIN: if (pipe_vld_q == 4'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Stage 0 loads together with the issue register; stage 3 lines up with
    // the PE rounder output, so the capture edge is four edges after issue.
    pipe_vld_d  = {pipe_vld_q[2:0], issue_rnd_d};
    pipe_slot_d = {pipe_slot_q[2:0], issue_slot_d};
    res_valid_d = pipe_vld_q[3];
    res_data_d  = pipe_vld_q[3] ? pe_data_out : '0;
    res_idx_d   = pipe_vld_q[3] ? pipe_slot_q[3] : 4'd0;

    op_ready_d  = (state_d == S_RUN);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    pe_rst_n_d  = (state_d != S_CLEAR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      k_len_q      <= '0;
      num_out_q    <= '0;
      term_cnt_q   <= '0;
      acc_cnt_q    <= '0;
      op_ready_q   <= 1'b0;
      pe_rst_n_q   <= 1'b0;
      issue_a_q    <= '0;
      issue_b_q    <= '0;
      issue_slot_q <= '0;
      issue_rnd_q  <= 1'b0;
      pipe_vld_q   <= '0;
      pipe_slot_q  <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_idx_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_len_q      <= k_len_d;
      num_out_q    <= num_out_d;
      term_cnt_q   <= term_cnt_d;
      acc_cnt_q    <= acc_cnt_d;
      op_ready_q   <= op_ready_d;
      pe_rst_n_q   <= pe_rst_n_d;
      issue_a_q    <= issue_a_d;
      issue_b_q    <= issue_b_d;
      issue_slot_q <= issue_slot_d;
      issue_rnd_q  <= issue_rnd_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_slot_q  <= pipe_slot_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_idx_q    <= res_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign op_ready      = op_ready_q;
  assign pe_rst_n      = pe_rst_n_q;
  assign pe_data_in_1  = issue_a_q;
  assign pe_data_in_2  = issue_b_q;
  assign pe_add_number = issue_slot_q;
  assign pe_rounder_en = issue_rnd_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_idx       = res_idx_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;
  assign dbg_state     = state_q;

endmodule
